// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: runs one req/ack bus read per fetch, stalls the PC while it is outstanding.
// Optional bus timeout is enabled with `define IFETCH_TIMEOUT_EN.
module inst_fetch_resp #(
    parameter int          ADDR_WIDTH     = 32,
    parameter logic [31:0] NOP_INST       = 32'h00000013,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  ce_i,
    input  logic                  flush_i,
    output logic                  stall_req_o,
    output logic [31:0]           inst_o,
    output logic                  inst_valid_o,
    output logic                  fetch_err_o,
    output logic                  ibus_req_o,
    output logic [ADDR_WIDTH-1:0] ibus_addr_o,
    input  logic                  ibus_ack_i,
    input  logic [31:0]           ibus_data_i
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_e;

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic                  timeout;

    // Byte offset of the PC is irrelevant: fetches are always word aligned.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc_i[1:0];

`ifdef IFETCH_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // cnt_q counts no-ack cycles already spent; this cycle is the last allowed one.
    assign timeout = (cnt_q == 8'(TIMEOUT_CYCLES - 1)) && !ibus_ack_i;

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q && state_d != S_IDLE) begin
            cnt_d = 8'd0;
        end else if (state_q != S_IDLE && !ibus_ack_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign err_d = (state_q == S_WAIT) && !flush_i && timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err_o = err_q;
`else
    assign timeout     = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        valid_d     = 1'b0;
        stall_req_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_req_o = ce_i & ~flush_i;
                if (ce_i && !flush_i) begin
                    addr_d  = {pc_i[ADDR_WIDTH-1:2], 2'b00};
                    req_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_req_o = ~ibus_ack_i;
                if (ibus_ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                    // A flush in the ack cycle wins: the returned word is from the wrong path.
                    if (flush_i) begin
                        inst_d = NOP_INST;
                    end else begin
                        inst_d  = ibus_data_i;
                        valid_d = 1'b1;
                    end
                end else if (flush_i) begin
                    inst_d  = NOP_INST;
                    state_d = S_DISCARD;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    inst_d  = NOP_INST;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                stall_req_o = 1'b1;
                if (ibus_ack_i || timeout) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign ibus_req_o   = req_q;
    assign ibus_addr_o  = addr_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scoreboard bench for inst_fetch_resp: driver pushes expected words, monitor pops them on inst_valid_o.
module tb_inst_fetch_resp;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pc_i = '0;
    logic        ce_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        stall_req_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        fetch_err_o;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i = 1'b0;
    logic [31:0] ibus_data_i = '0;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    inst_fetch_resp #(.ADDR_WIDTH(32), .NOP_INST(NOP), .TIMEOUT_CYCLES(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .pc_i        (pc_i),
        .ce_i        (ce_i),
        .flush_i     (flush_i),
        .stall_req_o (stall_req_o),
        .inst_o      (inst_o),
        .inst_valid_o(inst_valid_o),
        .fetch_err_o (fetch_err_o),
        .ibus_req_o  (ibus_req_o),
        .ibus_addr_o (ibus_addr_o),
        .ibus_ack_i  (ibus_ack_i),
        .ibus_data_i (ibus_data_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Advance to the next cycle; inputs change just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: every valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst_i && inst_valid_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got inst %h want no valid", inst_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (inst_o !== e) begin
                    bad++;
                    $display("FAIL valid_data: got %h want %h", inst_o, e);
                end
            end
        end
    end

    initial begin
        // Reset
        cyc(); cyc();
        rst_i = 1'b0;
        mid();
        chk("rst_req", {31'd0, ibus_req_o}, 32'd0);
        chk("rst_addr", ibus_addr_o, 32'd0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_err", {31'd0, fetch_err_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd0);

        // Zero-wait fetch
        cyc(); ce_i = 1'b1; pc_i = 32'h100; exp_q.push_back(32'hDEADBEEF);
        mid(); chk("t1_stall_N", {31'd0, stall_req_o}, 32'd1);
        cyc(); ce_i = 1'b0; ibus_ack_i = 1'b1; ibus_data_i = 32'hDEADBEEF;
        mid(); chk("t1_addr", ibus_addr_o, 32'h100);
        chk("t1_req", {31'd0, ibus_req_o}, 32'd1);
        chk("t1_stall_ack", {31'd0, stall_req_o}, 32'd0);
        cyc(); ibus_ack_i = 1'b0;
        mid(); chk("t1_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("t1_inst", inst_o, 32'hDEADBEEF);
        chk("t1_req_drop", {31'd0, ibus_req_o}, 32'd0);

        // Three wait states, unaligned PC
        begin
            int stall_cnt = 0;
            cyc(); ce_i = 1'b1; pc_i = 32'h203; exp_q.push_back(32'h12345678);
            mid(); stall_cnt += int'(stall_req_o);
            cyc(); ce_i = 1'b0;
            mid(); stall_cnt += int'(stall_req_o);
            chk("t2_addr", ibus_addr_o, 32'h200);
            for (int i = 0; i < 2; i++) begin
                cyc(); mid(); stall_cnt += int'(stall_req_o);
            end
            cyc(); ibus_ack_i = 1'b1; ibus_data_i = 32'h12345678;
            mid(); stall_cnt += int'(stall_req_o);
            chk("t2_stall_cycles", stall_cnt, 4);
            cyc(); ibus_ack_i = 1'b0;
            mid(); chk("t2_valid", {31'd0, inst_valid_o}, 32'd1);
            chk("t2_inst", inst_o, 32'h12345678);
        end

        // Flush while waiting, ack two cycles later
        cyc(); ce_i = 1'b1; pc_i = 32'h300;
        cyc(); ce_i = 1'b0; flush_i = 1'b1;
        mid(); chk("t3_stall_flush", {31'd0, stall_req_o}, 32'd1);
        cyc(); flush_i = 1'b0;
        mid(); chk("t3_stall_discard", {31'd0, stall_req_o}, 32'd1);
        chk("t3_inst_nop", inst_o, NOP);
        chk("t3_req_held", {31'd0, ibus_req_o}, 32'd1);
        cyc(); ibus_ack_i = 1'b1; ibus_data_i = 32'hBAD0BAD0;
        mid(); chk("t3_stall_dack", {31'd0, stall_req_o}, 32'd1);
        cyc(); ibus_ack_i = 1'b0;
        mid(); chk("t3_no_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("t3_req_off", {31'd0, ibus_req_o}, 32'd0);
        chk("t3_inst_still_nop", inst_o, NOP);
        cyc(); ce_i = 1'b1; pc_i = 32'h404; exp_q.push_back(32'hCAFE0001);
        cyc(); ce_i = 1'b0; ibus_ack_i = 1'b1; ibus_data_i = 32'hCAFE0001;
        mid(); chk("t3_new_addr", ibus_addr_o, 32'h404);
        cyc(); ibus_ack_i = 1'b0;
        mid(); chk("t3_new_inst", inst_o, 32'hCAFE0001);

        // Flush and ack in the same cycle
        cyc(); ce_i = 1'b1; pc_i = 32'h500;
        cyc(); ce_i = 1'b0; ibus_ack_i = 1'b1; flush_i = 1'b1; ibus_data_i = 32'hBAD1BAD1;
        cyc(); ibus_ack_i = 1'b0; flush_i = 1'b0;
        mid(); chk("t4_no_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("t4_inst_nop", inst_o, NOP);
        chk("t4_req_off", {31'd0, ibus_req_o}, 32'd0);
        chk("t4_idle_stall", {31'd0, stall_req_o}, 32'd0);

        // Reset in the middle of a wait
        cyc(); ce_i = 1'b1; pc_i = 32'h704; exp_q.push_back(32'h00500093);
        cyc(); ce_i = 1'b0; ibus_ack_i = 1'b1; ibus_data_i = 32'h00500093;
        cyc(); ibus_ack_i = 1'b0;
        cyc(); ce_i = 1'b1; pc_i = 32'h600;
        cyc(); ce_i = 1'b0; rst_i = 1'b1;
        cyc(); rst_i = 1'b0; ibus_ack_i = 1'b1; ibus_data_i = 32'hBAD2BAD2;
        mid(); chk("t5_req", {31'd0, ibus_req_o}, 32'd0);
        chk("t5_addr", ibus_addr_o, 32'd0);
        chk("t5_inst", inst_o, NOP);
        cyc(); ibus_ack_i = 1'b0;
        mid(); chk("t5_no_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("t5_inst_after", inst_o, NOP);

        // Ack never arrives
        cyc(); ce_i = 1'b1; pc_i = 32'h800;
`ifdef IFETCH_TIMEOUT_EN
        exp_q.push_back(NOP);
`endif
        cyc(); ce_i = 1'b0;
        for (int i = 0; i < 15; i++) cyc();
        // Sixteen no-ack cycles have elapsed in WAIT.
        cyc();
        mid();
`ifdef IFETCH_TIMEOUT_EN
        chk("t6_err", {31'd0, fetch_err_o}, 32'd1);
        chk("t6_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("t6_inst", inst_o, NOP);
        chk("t6_req", {31'd0, ibus_req_o}, 32'd0);
`else
        chk("t6_err", {31'd0, fetch_err_o}, 32'd0);
        chk("t6_req_held", {31'd0, ibus_req_o}, 32'd1);
        chk("t6_stall", {31'd0, stall_req_o}, 32'd1);
        for (int i = 0; i < 4; i++) cyc();
        mid(); chk("t6_req_still", {31'd0, ibus_req_o}, 32'd1);
`endif
        cyc(); rst_i = 1'b1;
        cyc(); rst_i = 1'b0;
        cyc();
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
